// File: rtl/matmult_result_collector_if.sv
// Result-stream bundle between the matmult kernel, the result collector and the host output port.
// The collector takes the slave modport; the kernel/host side takes the master modport.
interface matmult_result_collector_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned OUT_W  = 16
) ();

    // Kernel side
    logic                     Start;
    logic signed [DATA_W-1:0] C;
    logic                     Wr_en;
    logic [ADDR_W-1:0]        Wr_addr;

    // Host output stream
    logic                     Out_valid;
    logic                     Out_ready;
    logic [OUT_W-1:0]         Out_data;
    logic                     Out_last;

    // Status
    logic                     Done;
    logic                     Busy;
    logic                     Err_ovf;
    logic                     Sat_flag;

    modport master (
        output Start, C, Wr_en, Wr_addr, Out_ready,
        input  Out_valid, Out_data, Out_last, Done, Busy, Err_ovf, Sat_flag
    );

    modport slave (
        input  Start, C, Wr_en, Wr_addr, Out_ready,
        output Out_valid, Out_data, Out_last, Done, Busy, Err_ovf, Sat_flag
    );

endinterface

// File: rtl/matmult_result_collector.sv
// Result collector for the 16x16 dot-product pipeline: captures the kernel's scattered result
// writes into a buffer, waits until every address has been written once, then drains the
// matrix in address order over a valid/ready stream and pulses Done after the last beat.
// Optional feature: define RESULT_SAT_EN to saturate results to the signed OUT_W range and
// report clamped entries on Sat_flag; otherwise results wrap and Sat_flag is tied low.
module matmult_result_collector #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned OUT_W  = 16
) (
    input logic                         Clk,
    input logic                         Rst,
    matmult_result_collector_if.slave   bus
);

    typedef enum logic [1:0] {StIdle, StCollect, StDrain} state_e;

`ifdef RESULT_SAT_EN
    // Stored entry carries a "was clamped" bit above the converted data.
    localparam int unsigned EntW = OUT_W + 1;
    localparam logic signed [DATA_W-1:0] SatMax = {{(DATA_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] SatMin = {{(DATA_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
`else
    localparam int unsigned EntW = OUT_W;
`endif

    localparam logic [ADDR_W:0]   CountOne  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   CountLast = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] PtrOne    = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] PtrLast   = ADDR_W'(DEPTH - 1);

    state_e            state_q, state_d;
    logic [DEPTH-1:0]  vbit_q, vbit_d;
    logic [ADDR_W:0]   wr_count_q, wr_count_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic              out_valid_q, out_valid_d;
    logic [EntW-1:0]   out_ent_q, out_ent_d;
    logic              done_q, done_d;
    logic              err_ovf_q, err_ovf_d;
`ifdef RESULT_SAT_EN
    logic              sat_flag_q, sat_flag_d;
`endif

    // Result buffer; contents are deliberately not reset.
    logic [EntW-1:0]   mem_q [DEPTH];

    logic              wr_accept;
    logic              wr_new;
    logic              full_write;
    logic              handshake;
    logic              is_last;
    logic [ADDR_W-1:0] rd_addr;
    logic [EntW-1:0]   wr_ent;

    // A write is taken in COLLECT, or alongside Start as the first entry of a new collection.
    assign wr_accept  = bus.Wr_en && (bus.Start || (state_q == StCollect));
    // Start clears the bitmap, so a write beside Start is always a fresh address.
    assign wr_new     = wr_accept && (bus.Start || !vbit_q[bus.Wr_addr]);
    assign full_write = (state_q == StCollect) && !bus.Start && wr_new && (wr_count_q == CountLast);
    assign handshake  = (state_q == StDrain) && out_valid_q && bus.Out_ready;
    assign is_last    = (rd_ptr_q == PtrLast);
    // Look one entry ahead on a handshake so back-to-back beats need no bubble.
    assign rd_addr    = handshake ? (rd_ptr_q + PtrOne) : rd_ptr_q;

    // Convert the incoming result to the output width at write time.
`ifdef RESULT_SAT_EN
    always_comb begin
        if ($signed(bus.C) > SatMax) begin
            wr_ent = {1'b1, 1'b0, {(OUT_W-1){1'b1}}};
        end else if ($signed(bus.C) < SatMin) begin
            wr_ent = {1'b1, 1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            wr_ent = {1'b0, bus.C[OUT_W-1:0]};
        end
    end
`else
    logic unused_c_hi;
    assign wr_ent      = bus.C[OUT_W-1:0];
    assign unused_c_hi = ^bus.C[DATA_W-1:OUT_W];
`endif

    // Buffer write port.
    always_ff @(posedge Clk) begin
        if (!Rst && wr_accept) begin
            mem_q[bus.Wr_addr] <= wr_ent;
        end
    end

    // FSM state register.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; Start from any state (re)arms a collection.
    always_comb begin
        state_d = state_q;
        if (bus.Start) begin
            state_d = StCollect;
        end else begin
            case (state_q)
                StIdle:    state_d = StIdle;
                StCollect: if (full_write) state_d = StDrain;
                StDrain:   if (handshake && is_last) state_d = StIdle;
                default:   state_d = StIdle;
            endcase
        end
    end

    // FSM datapath/output next values: bitmap, counters, prefetch register and flags.
    always_comb begin
        vbit_d      = vbit_q;
        wr_count_d  = wr_count_q;
        rd_ptr_d    = rd_ptr_q;
        out_valid_d = out_valid_q;
        out_ent_d   = out_ent_q;
        done_d      = 1'b0;
        err_ovf_d   = err_ovf_q;
`ifdef RESULT_SAT_EN
        sat_flag_d  = sat_flag_q;
`endif
        if (bus.Start) begin
            vbit_d      = '0;
            wr_count_d  = '0;
            rd_ptr_d    = '0;
            out_valid_d = 1'b0;
            err_ovf_d   = 1'b0;
`ifdef RESULT_SAT_EN
            sat_flag_d  = 1'b0;
`endif
            if (wr_accept) begin
                vbit_d[bus.Wr_addr] = 1'b1;
                wr_count_d          = CountOne;
            end
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.Wr_en) err_ovf_d = 1'b1;
                end
                StCollect: begin
                    if (wr_accept) begin
                        vbit_d[bus.Wr_addr] = 1'b1;
                        if (wr_new) wr_count_d = wr_count_q + CountOne;
                    end
                end
                StDrain: begin
                    if (bus.Wr_en) err_ovf_d = 1'b1;
                    if (!out_valid_q) begin
                        // First prefetch of the drain: entry at rd_ptr (0).
                        out_valid_d = 1'b1;
                        out_ent_d   = mem_q[rd_addr];
                    end else if (handshake) begin
`ifdef RESULT_SAT_EN
                        if (out_ent_q[EntW-1]) sat_flag_d = 1'b1;
`endif
                        if (is_last) begin
                            out_valid_d = 1'b0;
                            rd_ptr_d    = '0;
                            done_d      = 1'b1;
                        end else begin
                            rd_ptr_d  = rd_addr;
                            out_ent_d = mem_q[rd_addr];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            vbit_q      <= '0;
            wr_count_q  <= '0;
            rd_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_ent_q   <= '0;
            done_q      <= 1'b0;
            err_ovf_q   <= 1'b0;
`ifdef RESULT_SAT_EN
            sat_flag_q  <= 1'b0;
`endif
        end else begin
            vbit_q      <= vbit_d;
            wr_count_q  <= wr_count_d;
            rd_ptr_q    <= rd_ptr_d;
            out_valid_q <= out_valid_d;
            out_ent_q   <= out_ent_d;
            done_q      <= done_d;
            err_ovf_q   <= err_ovf_d;
`ifdef RESULT_SAT_EN
            sat_flag_q  <= sat_flag_d;
`endif
        end
    end

    assign bus.Out_valid = out_valid_q;
    assign bus.Out_data  = out_ent_q[OUT_W-1:0];
    assign bus.Out_last  = out_valid_q && is_last;
    assign bus.Done      = done_q;
    assign bus.Busy      = (state_q != StIdle);
    assign bus.Err_ovf   = err_ovf_q;
`ifdef RESULT_SAT_EN
    assign bus.Sat_flag  = sat_flag_q;
`else
    assign bus.Sat_flag  = 1'b0;
`endif

endmodule
